// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types for the two-requester LSU arbiter.
//   state_t  - arbiter FSM states
//   req_id_t - requester index (0 = core, 1 = debug/loader)
//   txn_t    - request fields latched at arbitration time
//   SZ_*     - access size encodings carried on *_size
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef logic req_id_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    req_id_t     id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [1:0]  size;
  } txn_t;

endpackage

// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: requester-side and LSU-side bus of the LSU arbiter.
//   i_mN_*       - request from requester N (req held until o_mN_gnt)
//   o_mN_gnt     - one-cycle grant pulse
//   o_mN_rvalid  - one-cycle load-response pulse, o_mN_rdata valid
//   o_lsu_*      - address/store data/size/write enable to the LSU
//   i_ld_data    - load data returned by the LSU
// modport slave is the arbiter's view, master is the requester/LSU model's view.
interface lsu_arbiter_if;
  logic        i_m0_req;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic        i_m0_wren;
  logic [1:0]  i_m0_size;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic [31:0] o_m0_rdata;

  logic        i_m1_req;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic        i_m1_wren;
  logic [1:0]  i_m1_size;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_m1_rdata;

  logic [31:0] o_lsu_addr;
  logic [31:0] o_lsu_st_data;
  logic [1:0]  o_lsu_size;
  logic        o_lsu_wren;
  logic [31:0] i_ld_data;

  modport slave (
    input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_size,
    input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_size,
    input  i_ld_data,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_lsu_addr, o_lsu_st_data, o_lsu_size, o_lsu_wren
  );

  modport master (
    output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_size,
    output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_size,
    output i_ld_data,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_lsu_addr, o_lsu_st_data, o_lsu_size, o_lsu_wren
  );
endinterface

// File: rtl/lsu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[1:0] - pending requests
//   last_id  - requester granted most recently
//   valid    - at least one request pending
//   winner   - selected requester; on a tie the one not granted last
module rr_arb2
  import lsu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_id,
  output logic       valid,
  output req_id_t    winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_id;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: arbitrates two requesters onto one LSU port.
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-high reset
//   bus      - requester/LSU bus (lsu_arbiter_if.slave)
//   o_busy   - high whenever the FSM is not IDLE
// P_LD_LAT (0..3) is the number of cycles from the ISSUE cycle to the edge at
// which i_ld_data is sampled.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned P_LD_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  lsu_arbiter_if.slave bus,
  output logic         o_busy
);

  localparam logic [1:0] CNT_INIT = (P_LD_LAT == 0) ? 2'd0 : 2'(P_LD_LAT - 1);

  state_t      state_q;
  state_t      state_d;
  txn_t        txn_q;
  txn_t        txn_d;
  req_id_t     last_id_q;
  logic [1:0]  cnt_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        ld_sample;
  logic        arb_valid;
  req_id_t     arb_winner;

  rr_arb2 u_rr_arb2 (
    .req     ({bus.i_m1_req, bus.i_m0_req}),
    .last_id (last_id_q),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  always_comb begin
    txn_d.id = arb_winner;
    if (arb_winner) begin
      txn_d.addr  = bus.i_m1_addr;
      txn_d.wdata = bus.i_m1_wdata;
      txn_d.wren  = bus.i_m1_wren;
      txn_d.size  = bus.i_m1_size;
    end else begin
      txn_d.addr  = bus.i_m0_addr;
      txn_d.wdata = bus.i_m0_wdata;
      txn_d.wren  = bus.i_m0_wren;
      txn_d.size  = bus.i_m0_size;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_sample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (txn_q.wren) begin
          state_d = ST_IDLE;
        end else if (P_LD_LAT == 0) begin
          ld_sample = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ld_sample = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Load data lands in the addressed requester's register at the sample edge;
  // the other requester's register is untouched.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      txn_q     <= '0;
      last_id_q <= 1'b1;
      cnt_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && arb_valid) txn_q <= txn_d;
      if (state_q == ST_ISSUE) begin
        last_id_q <= txn_q.id;
        if (!txn_q.wren) cnt_q <= CNT_INIT;
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (ld_sample) begin
        if (txn_q.id) rdata1_q <= bus.i_ld_data;
        else          rdata0_q <= bus.i_ld_data;
      end
    end
  end

  assign bus.o_m0_gnt      = (state_q == ST_ISSUE) && !txn_q.id;
  assign bus.o_m1_gnt      = (state_q == ST_ISSUE) &&  txn_q.id;
  assign bus.o_m0_rvalid   = (state_q == ST_RESP)  && !txn_q.id;
  assign bus.o_m1_rvalid   = (state_q == ST_RESP)  &&  txn_q.id;
  assign bus.o_m0_rdata    = rdata0_q;
  assign bus.o_m1_rdata    = rdata1_q;
  assign bus.o_lsu_addr    = txn_q.addr;
  assign bus.o_lsu_st_data = txn_q.wdata;
  assign bus.o_lsu_size    = txn_q.size;
  assign bus.o_lsu_wren    = (state_q == ST_ISSUE) && txn_q.wren;
  assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: three arbiters (load latency 0, 1, 3) driven from task-level
// stimulus; expected timing and data come from transaction-level arithmetic.
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  logic clk;
  logic rst;

  logic        req   [3][2];
  logic [31:0] addr  [3][2];
  logic [31:0] wdata [3][2];
  logic        wren  [3][2];
  logic [1:0]  size  [3][2];
  logic [31:0] ld_data [3];

  logic        gnt    [3][2];
  logic        rvalid [3][2];
  logic [31:0] rdata  [3][2];
  logic [31:0] lsu_addr [3];
  logic [31:0] st_data  [3];
  logic [1:0]  lsu_size [3];
  logic        lsu_wren [3];
  logic        busy     [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata [3][2];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_arbiter_if bus ();
    assign bus.i_m0_req   = req[g][0];
    assign bus.i_m0_addr  = addr[g][0];
    assign bus.i_m0_wdata = wdata[g][0];
    assign bus.i_m0_wren  = wren[g][0];
    assign bus.i_m0_size  = size[g][0];
    assign bus.i_m1_req   = req[g][1];
    assign bus.i_m1_addr  = addr[g][1];
    assign bus.i_m1_wdata = wdata[g][1];
    assign bus.i_m1_wren  = wren[g][1];
    assign bus.i_m1_size  = size[g][1];
    assign bus.i_ld_data  = ld_data[g];
    assign gnt[g][0]    = bus.o_m0_gnt;
    assign gnt[g][1]    = bus.o_m1_gnt;
    assign rvalid[g][0] = bus.o_m0_rvalid;
    assign rvalid[g][1] = bus.o_m1_rvalid;
    assign rdata[g][0]  = bus.o_m0_rdata;
    assign rdata[g][1]  = bus.o_m1_rdata;
    assign lsu_addr[g]  = bus.o_lsu_addr;
    assign st_data[g]   = bus.o_lsu_st_data;
    assign lsu_size[g]  = bus.o_lsu_size;
    assign lsu_wren[g]  = bus.o_lsu_wren;

    lsu_arbiter #(.P_LD_LAT((g == 0) ? 0 : ((g == 1) ? 1 : 3))) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus),
      .o_busy  (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_rdata[k][0] = '0;
      exp_rdata[k][1] = '0;
    end
  endtask

  task automatic test_reset();
    logic [205:0] obs;
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      obs = {gnt[k][0], gnt[k][1], rvalid[k][0], rvalid[k][1], rdata[k][0], rdata[k][1],
             lsu_addr[k], st_data[k], lsu_size[k], lsu_wren[k], busy[k], 64'd0, 1'b0};
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %h, want all zero", k, obs);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_rdata[k][0] = '0;
      exp_rdata[k][1] = '0;
    end
  endtask

  // One request from requester id on dut k, starting with the dut idle.
  task automatic do_txn(input int k, input int id, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s,
                        input logic use_fix, input logic [31:0] fix);
    int p, other, waited, rv_at, busy_end, leak, busy_err;
    logic [31:0] v [9];
    logic [31:0] got_rdata;
    logic [66:0] obs, expv;
    p = lat_of(k);
    other = 1 - id;
    req[k][id] = 1'b1; addr[k][id] = a; wdata[k][id] = d; wren[k][id] = w; size[k][id] = s;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!gnt[k][id] && waited < 20);
    total++;
    if (!gnt[k][id] || waited != 1) begin
      bad++;
      $display("FAIL gnt_latency dut%0d m%0d: got %0d cycles (gnt=%b), want 1", k, id, waited, gnt[k][id]);
    end
    if (!gnt[k][id]) begin
      req[k][id] = 1'b0;
      repeat (8) @(negedge clk);
      return;
    end
    obs  = {lsu_addr[k], st_data[k], lsu_size[k], lsu_wren[k], gnt[k][other]};
    expv = {a, d, s, w, 1'b0};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL issue_fields dut%0d m%0d: got %h, want %h", k, id, obs, expv);
    end
    req[k][id] = 1'b0;
    v[0] = use_fix ? fix : $urandom;
    ld_data[k] = v[0];
    rv_at = -1; leak = 0; busy_err = 0; got_rdata = '0;
    busy_end = w ? 1 : p + 2;
    for (int j = 1; j <= p + 5; j++) begin
      @(negedge clk);
      if (rvalid[k][id] === 1'b1 && rv_at < 0) begin
        rv_at = j;
        got_rdata = rdata[k][id];
      end
      if (lsu_wren[k] !== 1'b0 || rvalid[k][other] !== 1'b0 || gnt[k][0] !== 1'b0 || gnt[k][1] !== 1'b0)
        leak++;
      if (busy[k] !== (j < busy_end)) busy_err++;
      v[j] = use_fix ? fix : $urandom;
      ld_data[k] = v[j];
    end
    total++;
    if (rv_at != (w ? -1 : p + 1)) begin
      bad++;
      $display("FAIL rvalid_timing dut%0d m%0d: got cycle %0d, want %0d", k, id, rv_at, w ? -1 : p + 1);
    end
    total++;
    if (leak != 0) begin
      bad++;
      $display("FAIL quiet_after_issue dut%0d m%0d: got %0d stray wren/gnt/rvalid cycles, want 0", k, id, leak);
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL busy_window dut%0d m%0d: got %0d wrong busy cycles, want 0", k, id, busy_err);
    end
    if (!w) begin
      total++;
      if (got_rdata !== v[p]) begin
        bad++;
        $display("FAIL load_data dut%0d m%0d: got %h, want %h", k, id, got_rdata, v[p]);
      end
      exp_rdata[k][id] = v[p];
    end
    total++;
    if (rdata[k][other] !== exp_rdata[k][other]) begin
      bad++;
      $display("FAIL other_rdata_hold dut%0d m%0d: got %h, want %h", k, other, rdata[k][other], exp_rdata[k][other]);
    end
  endtask

  task automatic test_store();
    for (int k = 0; k < 3; k++)
      do_txn(k, 0, 1'b1, 32'h0000_7000, 32'h0000_00A5, SZ_WORD, 1'b0, '0);
  endtask

  task automatic test_load();
    do_txn(1, 1, 1'b0, 32'h0000_0010, '0, SZ_WORD, 1'b1, 32'hDEAD_BEEF);
    total++;
    if (rdata[1][1] !== 32'hDEAD_BEEF || rvalid[1][0] !== 1'b0) begin
      bad++;
      $display("FAIL load_m1 dut1: got rdata=%h m0_rvalid=%b, want DEADBEEF/0", rdata[1][1], rvalid[1][0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 10; n++) begin
        do_txn(k, int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom,
               2'($urandom_range(2, 0)), 1'b0, '0);
      end
    end
  endtask

  // Both requesters hold req from reset: m0 issues stores, m1 issues loads.
  task automatic test_contention(input int k);
    int p, grants, cyc, last_cyc, last_id, order_err, gap_err, both;
    logic [31:0] fixed;
    p = lat_of(k);
    fixed = 32'h0C0F_FEE0 ^ 32'(k);
    apply_reset();
    ld_data[k] = fixed;
    req[k][0] = 1'b1; addr[k][0] = 32'h100; wdata[k][0] = 32'h55; wren[k][0] = 1'b1; size[k][0] = SZ_BYTE;
    req[k][1] = 1'b1; addr[k][1] = 32'h200; wdata[k][1] = 32'h0;  wren[k][1] = 1'b0; size[k][1] = SZ_HALF;
    grants = 0; cyc = 0; last_cyc = 0; last_id = 1; order_err = 0; gap_err = 0; both = 0;
    while (grants < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (gnt[k][0] && gnt[k][1]) both++;
      if (gnt[k][0] || gnt[k][1]) begin
        if (int'(gnt[k][1]) != (grants % 2)) order_err++;
        if (grants > 0 && (cyc - last_cyc) != ((last_id == 0) ? 2 : p + 3)) gap_err++;
        last_id = gnt[k][1] ? 1 : 0;
        last_cyc = cyc;
        grants++;
      end
    end
    req[k][0] = 1'b0;
    req[k][1] = 1'b0;
    repeat (p + 4) @(negedge clk);
    exp_rdata[k][1] = fixed;
    total++;
    if (grants != 6 || order_err != 0 || both != 0) begin
      bad++;
      $display("FAIL rr_order dut%0d: got grants=%0d order_err=%0d double=%0d, want 6/0/0", k, grants, order_err, both);
    end
    total++;
    if (gap_err != 0) begin
      bad++;
      $display("FAIL rr_spacing dut%0d: got %0d wrong grant gaps, want 0", k, gap_err);
    end
    total++;
    if (rdata[k][1] !== fixed || busy[k] !== 1'b0) begin
      bad++;
      $display("FAIL rr_final dut%0d: got rdata=%h busy=%b, want %h/0", k, rdata[k][1], busy[k], fixed);
    end
  endtask

  task automatic test_reset_mid_load(input int k);
    int p, waited, stray;
    logic [205:0] obs;
    p = lat_of(k);
    apply_reset();
    ld_data[k] = 32'h1234_5678;
    req[k][0] = 1'b1; addr[k][0] = 32'h40; wren[k][0] = 1'b0; size[k][0] = SZ_WORD;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!gnt[k][0] && waited < 20);
    req[k][0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {gnt[k][0], gnt[k][1], rvalid[k][0], rvalid[k][1], rdata[k][0], rdata[k][1],
           lsu_addr[k], st_data[k], lsu_size[k], lsu_wren[k], busy[k], 64'd0, 1'b0};
    total++;
    if (waited != 1 || obs !== '0) begin
      bad++;
      $display("FAIL reset_in_wait dut%0d: got waited=%0d outputs=%h, want 1/zero", k, waited, obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rdata[i][0] = '0;
      exp_rdata[i][1] = '0;
    end
    stray = 0;
    repeat (p + 4) begin
      @(negedge clk);
      if (gnt[k][0] || gnt[k][1] || rvalid[k][0] || rvalid[k][1] || busy[k]) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL dropped_txn dut%0d: got %0d active cycles after release, want 0", k, stray);
    end
    req[k][0] = 1'b1; wren[k][0] = 1'b1;
    req[k][1] = 1'b1; wren[k][1] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!gnt[k][0] && !gnt[k][1] && waited < 20);
    total++;
    if (gnt[k][0] !== 1'b1 || gnt[k][1] !== 1'b0) begin
      bad++;
      $display("FAIL tie_after_reset dut%0d: got gnt m0=%b m1=%b, want 1/0", k, gnt[k][0], gnt[k][1]);
    end
    req[k][0] = 1'b0;
    req[k][1] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_data[k] = '0;
      for (int i = 0; i < 2; i++) begin
        req[k][i] = 1'b0; addr[k][i] = '0; wdata[k][i] = '0; wren[k][i] = 1'b0; size[k][i] = '0;
        exp_rdata[k][i] = '0;
      end
    end
    @(negedge clk);
    test_reset();
    test_store();
    test_load();
    test_random();
    for (int k = 0; k < 3; k++) test_contention(k);
    test_reset_mid_load(1);
    test_reset_mid_load(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
